// File: rtl/bru_pkg.sv
// Shared branch-resolution definitions: prediction metadata layout, PC step
// and the control-transfer opcodes also used by the fetch predictor and decoder.
package bru_pkg;

  localparam int BRU_DATA_WIDTH = 32;
  localparam int PC_INCR        = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic                      valid;
    logic                      pred_taken;
    logic [BRU_DATA_WIDTH-1:0] pred_target;
    logic [BRU_DATA_WIDTH-1:0] pc_plus4;
  } bp_meta_t;

endpackage

// File: rtl/bru_meta_queue.sv
// DEPTH-entry shift register carrying prediction metadata from fetch to execute;
// holds while advance is low and invalidates every entry on flush.
import bru_pkg::*;

module bru_meta_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  fetch_valid,
  input  logic                  fetch_pred_taken,
  input  logic [DATA_WIDTH-1:0] fetch_pred_target,
  input  logic [DATA_WIDTH-1:0] fetch_pc_plus4,
  output logic                  tail_valid,
  output logic                  tail_pred_taken,
  output logic [DATA_WIDTH-1:0] tail_pred_target,
  output logic [DATA_WIDTH-1:0] tail_pc_plus4
);

  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0]      entry_pred_taken;
  logic [DATA_WIDTH-1:0] entry_pred_target [DEPTH];
  logic [DATA_WIDTH-1:0] entry_pc_plus4    [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid      <= '0;
      entry_pred_taken <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_pred_target[i] <= '0;
        entry_pc_plus4[i]    <= '0;
      end
    end else if (flush) begin
      // The instruction fetched during the flush cycle is wrong-path as well
      entry_valid <= '0;
    end else if (advance) begin
      entry_valid[0]       <= fetch_valid;
      entry_pred_taken[0]  <= fetch_pred_taken;
      entry_pred_target[0] <= fetch_pred_target;
      entry_pc_plus4[0]    <= fetch_pc_plus4;
      for (int i = 1; i < DEPTH; i++) begin
        entry_valid[i]       <= entry_valid[i-1];
        entry_pred_taken[i]  <= entry_pred_taken[i-1];
        entry_pred_target[i] <= entry_pred_target[i-1];
        entry_pc_plus4[i]    <= entry_pc_plus4[i-1];
      end
    end
  end

  assign tail_valid       = entry_valid[DEPTH-1];
  assign tail_pred_taken  = entry_pred_taken[DEPTH-1];
  assign tail_pred_target = entry_pred_target[DEPTH-1];
  assign tail_pc_plus4    = entry_pc_plus4[DEPTH-1];

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch resolution: compares carried predictions with the resolved
// outcome and raises flush/redirect. BRU_PERF_CNT_EN enables saturating statistics.
import bru_pkg::*;

module branch_resolution_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  fetch_valid,
  input  logic                  predict_taken_f,
  input  logic [DATA_WIDTH-1:0] branch_target_f,
  input  logic [DATA_WIDTH-1:0] PC_f,
  input  logic                  resolve_valid_e,
  input  logic                  actual_taken_e,
  input  logic [DATA_WIDTH-1:0] actual_target_e,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  logic                  tail_valid;
  logic                  tail_pred_taken;
  logic [DATA_WIDTH-1:0] tail_pred_target;
  logic [DATA_WIDTH-1:0] tail_pc_plus4;
  logic [DATA_WIDTH-1:0] fetch_pc_plus4;
  logic                  qualified;
  logic                  advance;

  assign fetch_pc_plus4 = PC_f + DATA_WIDTH'(PC_INCR);

  bru_meta_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_meta_queue (
    .clk               (clk),
    .rst_n             (rst_n),
    .advance           (advance),
    .flush             (mispredict),
    .fetch_valid       (fetch_valid),
    .fetch_pred_taken  (predict_taken_f),
    .fetch_pred_target (branch_target_f),
    .fetch_pc_plus4    (fetch_pc_plus4),
    .tail_valid        (tail_valid),
    .tail_pred_taken   (tail_pred_taken),
    .tail_pred_target  (tail_pred_target),
    .tail_pc_plus4     (tail_pc_plus4)
  );

  // An invalid tail with resolve_valid_e set is a bubble and is never judged
  assign qualified  = !stall && tail_valid && resolve_valid_e;
  assign mispredict = qualified &&
                      ((tail_pred_taken != actual_taken_e) ||
                       (tail_pred_taken && actual_taken_e && (tail_pred_target != actual_target_e)));
  assign redirect_pc = !mispredict    ? '0 :
                       actual_taken_e ? actual_target_e : tail_pc_plus4;
  assign advance     = !stall && !mispredict;

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (qualified && (branch_count != '1))
        branch_count <= branch_count + CNT_WIDTH'(1);
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Randomised and directed bench for branch_resolution_unit with a queue-level reference model.
module tb_branch_resolution_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef BRU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, stall, fetch_valid, predict_taken_f;
  logic          resolve_valid_e, actual_taken_e, mispredict;
  logic [DW-1:0] branch_target_f, PC_f, actual_target_e, redirect_pc;
  logic [CW-1:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolution_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_valid(fetch_valid),
    .predict_taken_f(predict_taken_f), .branch_target_f(branch_target_f), .PC_f(PC_f),
    .resolve_valid_e(resolve_valid_e), .actual_taken_e(actual_taken_e),
    .actual_target_e(actual_target_e), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  typedef struct {
    bit          v;
    bit          pt;
    logic [DW-1:0] tgt;
    logic [DW-1:0] pc4;
  } ent_t;

  ent_t          m [DEPTH];
  int            exp_bc, exp_mc;
  bit            exp_q, exp_mis;
  logic [DW-1:0] exp_red;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [CW-1:0] cnt(input int c);
    return PERF ? CW'(c) : '0;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m[i] = '{1'b0, 1'b0, '0, '0};
  endtask

  task automatic drive(input bit s, input bit fv, input bit pt, input logic [DW-1:0] tgt,
                       input logic [DW-1:0] pc, input bit rv, input bit at,
                       input logic [DW-1:0] atgt);
    @(negedge clk);
    stall = s; fetch_valid = fv; predict_taken_f = pt; branch_target_f = tgt; PC_f = pc;
    resolve_valid_e = rv; actual_taken_e = at; actual_target_e = atgt;
    #1;
    exp_q   = !s && m[DEPTH-1].v && rv;
    exp_mis = exp_q && ((m[DEPTH-1].pt != at) || (m[DEPTH-1].pt && at && m[DEPTH-1].tgt != atgt));
    exp_red = !exp_mis ? '0 : (at ? atgt : m[DEPTH-1].pc4);
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_q) exp_bc = sat_inc(exp_bc);
    if (exp_mis) begin
      exp_mc = sat_inc(exp_mc);
      model_clear();
    end else if (!stall) begin
      for (int i = DEPTH - 1; i > 0; i--) m[i] = m[i-1];
      m[0] = '{fetch_valid, predict_taken_f, branch_target_f, PC_f + 32'd4};
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, '0);
    tick();
  endtask

  // Fetch one control transfer, move it to the tail, then present its resolution
  task automatic send(input logic [DW-1:0] pc, input bit pt, input logic [DW-1:0] tgt,
                      input bit at, input logic [DW-1:0] atgt, input bit younger, input bit s);
    drive(0, 1, pt, tgt, pc, 0, 0, '0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      drive(0, younger, 0, '0, pc + DW'(4 * i), 0, 0, '0);
      tick();
    end
    drive(s, younger, 0, '0, pc + DW'(4 * DEPTH), 1, at, atgt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 0; fetch_valid = 1; predict_taken_f = 0; branch_target_f = '0; PC_f = 32'h10;
    resolve_valid_e = 1; actual_taken_e = 1; actual_target_e = 32'h80;
    model_clear(); exp_bc = 0; exp_mc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_mis got %0b want 0", mispredict); end
    vectors++; if (redirect_pc !== '0) begin miscompares++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
    vectors++; if (branch_count !== '0) begin miscompares++; $display("FAIL reset_bc got %0d want 0", branch_count); end
    vectors++; if (mispredict_count !== '0) begin miscompares++; $display("FAIL reset_mc got %0d want 0", mispredict_count); end
    rst_n = 1'b1;
    repeat (DEPTH) idle();
  endtask

  task automatic test_backward_taken();
    send(32'h100, 1, 32'h0F0, 1, 32'h0F0, 0, 0);
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL bwd_mis got %0b want 0", mispredict); end
    vectors++; if (redirect_pc !== '0) begin miscompares++; $display("FAIL bwd_redirect got %h want 0", redirect_pc); end
    tick();
    idle();
    drive(0, 0, 0, '0, '0, 0, 0, '0);
    vectors++; if (branch_count !== cnt(1)) begin miscompares++; $display("FAIL bwd_bc got %0d want %0d", branch_count, cnt(1)); end
    vectors++; if (mispredict_count !== cnt(0)) begin miscompares++; $display("FAIL bwd_mc got %0d want %0d", mispredict_count, cnt(0)); end
    tick();
  endtask

  task automatic test_forward_mispredict();
    send(32'h200, 0, 32'h240, 1, 32'h240, 1, 0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL fwd_mis got %0b want 1", mispredict); end
    vectors++; if (redirect_pc !== 32'h240) begin miscompares++; $display("FAIL fwd_redirect got %h want 240", redirect_pc); end
    tick();
    // Every entry, including the one fetched during the flush, must be gone
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 0, 0, '0, '0, 1, 1, 32'h999);
      vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL fwd_recover_mis[%0d] got %0b want 0", i, mispredict); end
      tick();
    end
    drive(0, 0, 0, '0, '0, 0, 0, '0);
    vectors++; if (mispredict_count !== cnt(1)) begin miscompares++; $display("FAIL fwd_mc got %0d want %0d", mispredict_count, cnt(1)); end
    vectors++; if (branch_count !== cnt(2)) begin miscompares++; $display("FAIL fwd_bc got %0d want %0d", branch_count, cnt(2)); end
    tick();
  endtask

  task automatic test_not_taken();
    send(32'h300, 1, 32'h2F0, 0, 32'h0, 0, 0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL nt_mis got %0b want 1", mispredict); end
    vectors++; if (redirect_pc !== 32'h304) begin miscompares++; $display("FAIL nt_redirect got %h want 304", redirect_pc); end
    tick();
    idle();
  endtask

  task automatic test_jalr();
    send(32'h400, 0, 32'h404, 1, 32'h1000, 1, 0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL jalr_mis got %0b want 1", mispredict); end
    vectors++; if (redirect_pc !== 32'h1000) begin miscompares++; $display("FAIL jalr_redirect got %h want 1000", redirect_pc); end
    tick();
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 0, 0, '0, '0, 1, 1, 32'h404);
      vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL jalr_squash_mis[%0d] got %0b want 0", i, mispredict); end
      tick();
    end
  endtask

  task automatic test_stall();
    send(32'h500, 0, 32'h0, 1, 32'h580, 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1, 0, 0, '0, '0, 1, 1, 32'h580);
      vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL stall_mis[%0d] got %0b want 0", i, mispredict); end
      vectors++; if (branch_count !== cnt(4)) begin miscompares++; $display("FAIL stall_bc[%0d] got %0d want %0d", i, branch_count, cnt(4)); end
      tick();
    end
    drive(0, 0, 0, '0, '0, 1, 1, 32'h580);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL unstall_mis got %0b want 1", mispredict); end
    vectors++; if (redirect_pc !== 32'h580) begin miscompares++; $display("FAIL unstall_redirect got %h want 580", redirect_pc); end
    tick();
    drive(0, 0, 0, '0, '0, 0, 0, '0);
    vectors++; if (branch_count !== cnt(5)) begin miscompares++; $display("FAIL stall_bc_after got %0d want %0d", branch_count, cnt(5)); end
    vectors++; if (mispredict_count !== cnt(4)) begin miscompares++; $display("FAIL stall_mc_after got %0d want %0d", mispredict_count, cnt(4)); end
    tick();
  endtask

  task automatic test_wrap();
    send(32'hFFFF_FFFC, 1, 32'h10, 0, 32'h0, 0, 0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL wrap_mis got %0b want 1", mispredict); end
    vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_redirect got %h want 0", redirect_pc); end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] tgt, atgt;
    bit s, rv, at, pt;
    for (int n = 0; n < 400; n++) begin
      s    = ($urandom_range(0, 4) == 0);
      rv   = $urandom_range(0, 1);
      at   = $urandom_range(0, 1);
      pt   = $urandom_range(0, 1);
      tgt  = DW'($urandom_range(0, 3)) << 4;
      atgt = $urandom_range(0, 1) ? m[DEPTH-1].tgt : (DW'($urandom_range(0, 3)) << 4);
      drive(s, 1'($urandom_range(0, 1)), pt, tgt, $urandom & ~32'h3, rv, at, atgt);
      vectors++; if (mispredict !== exp_mis) begin miscompares++; $display("FAIL rnd_mis[%0d] got %0b want %0b", n, mispredict, exp_mis); end
      vectors++; if (redirect_pc !== exp_red) begin miscompares++; $display("FAIL rnd_redirect[%0d] got %h want %h", n, redirect_pc, exp_red); end
      vectors++; if (branch_count !== cnt(exp_bc)) begin miscompares++; $display("FAIL rnd_bc[%0d] got %0d want %0d", n, branch_count, cnt(exp_bc)); end
      vectors++; if (mispredict_count !== cnt(exp_mc)) begin miscompares++; $display("FAIL rnd_mc[%0d] got %0d want %0d", n, mispredict_count, cnt(exp_mc)); end
      tick();
    end
    repeat (DEPTH) idle();
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0, '0, 32'h900, 0, 0, '0); tick();
    for (int i = 1; i < DEPTH; i++) begin drive(0, 1, 0, '0, 32'h900 + DW'(4 * i), 0, 0, '0); tick(); end
    drive(0, 0, 0, '0, '0, 1, 1, 32'h990);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL arst_pre_mis got %0b want 1", mispredict); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL arst_mis got %0b want 0", mispredict); end
    vectors++; if (redirect_pc !== '0) begin miscompares++; $display("FAIL arst_redirect got %h want 0", redirect_pc); end
    vectors++; if (branch_count !== '0) begin miscompares++; $display("FAIL arst_bc got %0d want 0", branch_count); end
    vectors++; if (mispredict_count !== '0) begin miscompares++; $display("FAIL arst_mc got %0d want 0", mispredict_count); end
    model_clear(); exp_bc = 0; exp_mc = 0;
    @(negedge clk) rst_n = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < CMAX + 3; k++) begin
      send(32'h2000 + DW'(k * 64), 0, 32'h0, 1, 32'h40, 0, 0);
      vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL sat_mis[%0d] got %0b want 1", k, mispredict); end
      tick();
    end
    drive(0, 0, 0, '0, '0, 0, 0, '0);
    vectors++; if (branch_count !== cnt(CMAX)) begin miscompares++; $display("FAIL sat_bc got %0d want %0d", branch_count, cnt(CMAX)); end
    vectors++; if (mispredict_count !== cnt(CMAX)) begin miscompares++; $display("FAIL sat_mc got %0d want %0d", mispredict_count, cnt(CMAX)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_backward_taken();
    test_forward_mispredict();
    test_not_taken();
    test_jalr();
    test_stall();
    test_wrap();
    test_random();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-stage counterpart to the fetch-stage static branch predictor.
- Carries each fetched instruction's prediction metadata (predict_taken, predicted target, PC+4) down to execute, compares it with the resolved outcome, and raises flush plus redirect PC on a mispredict.
- Optionally keeps branch and mispredict statistics.
- Sits beside the hazard unit; its outputs feed the PC mux and the F/D and D/E flush controls.

Parameters:
- DATA_WIDTH, 32, address/data width.
- DEPTH, 2, metadata pipeline stages from fetch to execute; legal range is 1 or more.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit stall; holds the metadata pipeline
- fetch_valid  in  1  instruction accepted in fetch this cycle
- predict_taken_f  in  1  prediction from the fetch-stage predictor
- branch_target_f  in  DATA_WIDTH  predicted target
- PC_f  in  DATA_WIDTH  fetch PC
- resolve_valid_e  in  1  instruction in execute is B-type, JAL or JALR
- actual_taken_e  in  1  resolved outcome (JAL/JALR = 1)
- actual_target_e  in  DATA_WIDTH  resolved target
- mispredict  out  1  flush F/D and D/E this cycle
- redirect_pc  out  DATA_WIDTH  PC to load on mispredict
- branch_count  out  CNT_WIDTH  resolved control transfers
- mispredict_count  out  CNT_WIDTH  mispredicts

Behaviour:
- Reset (async, rst_n=0): all queue entries are invalid with zero fields; mispredict=0, redirect_pc=0, counters=0.
- Queue entry fields: {valid, pred_taken, pred_target, pc_plus4}. pc_plus4 = PC_f + 4, truncated modulo 2^DATA_WIDTH, so 0xFFFFFFFC wraps to 0.
- Advance, on a rising edge with stall=0 and mispredict=0:
  - entry[0] takes the fetch inputs, with valid=fetch_valid.
  - entry[i] takes entry[i-1].
  - entry[DEPTH-1] feeds execute.
- stall=1: every entry holds. Mispredict is forced to 0 and counters hold.
- Tail entry E = entry[DEPTH-1]. E.valid=0 while resolve_valid_e=1 is a pipeline-bubble mismatch: no mispredict is raised, and the event does not count.
- Compare, combinational, evaluated when stall=0, E.valid=1 and resolve_valid_e=1. Mispredict is raised when either holds:
  - pred_taken != actual_taken_e
  - both taken and pred_target != actual_target_e
  - Consequence: a taken JALR (always predicted not-taken) always mispredicts.
- redirect_pc:
  - actual_taken_e=1: actual_target_e.
  - actual_taken_e=0: E.pc_plus4.
  - Driven as 0 when mispredict=0.
- Latency: mispredict and redirect_pc are asserted in the same cycle as resolution (0-cycle).
- Flush on the clock edge where mispredict=1:
  - All entries are set invalid, including the one fetched that cycle.
  - The next cycle is a recovery cycle: resolve_valid_e is ignored because E is invalid.
- A non-branch in execute (resolve_valid_e=0) simply retires its entry.
- Two control transfers back to back: the second is evaluated normally unless the first mispredicted, in which case it is squashed.
- Counters saturate at all-ones; they do not wrap.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - branch_count increments on every qualified resolve (stall=0, E.valid, resolve_valid_e).
  - mispredict_count increments when mispredict=1.
  - Both saturate.
- Undefined: no counter flops; both outputs are tied to 0.

Decomposition:
- Package bru_pkg holds:
  - typedef bp_meta_t (packed struct of the entry fields, parameterised via DATA_WIDTH localparam);
  - localparam PC_INCR = 4;
  - opcode constants OPC_BRANCH 7'b1100011, OPC_JAL 7'b1101111, OPC_JALR 7'b1100111, shared with the predictor and decoder.
- One sub-module: bru_meta_queue, the DEPTH-entry shift register with stall-hold and flush-clear.
- Comparison logic and counters stay in the top module.

Test Plan:
- Backward branch: PC_f=0x100, predict_taken=1, target=0x0F0. After DEPTH advances, resolve taken to 0x0F0 -> mispredict=0, branch_count=1.
- Forward branch: PC_f=0x200, predict_taken=0. Resolve taken to 0x240 -> mispredict=1, redirect_pc=0x240. Next cycle all entries invalid; mispredict_count=1.
- Backward branch predicted taken (PC 0x300, target 0x2F0), resolved not taken -> mispredict=1, redirect_pc=0x304.
- JALR at 0x400 predicted not taken, resolved taken to 0x1000 -> mispredict=1, redirect_pc=0x1000. Younger entry at 0x404 squashed; no second resolve.
- stall held 3 cycles while a mispredicting branch sits in E -> mispredict=0 throughout the stall. Fires on the first cycle with stall=0; counters change exactly once.
- rst_n pulsed low mid-stream with valid entries -> outputs and counters are 0 immediately (asynchronously). Also: PC_f=0xFFFFFFFC wraps to pc_plus4=0, and preloaded saturated counters stay at all-ones.
